multicycle_controller: RTL and testbench

//  Parametrised multicycle successor to the single-cycle LEGv8 decoder. Holds an internal

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 controller: owns the instruction register and sequences
// FETCH/DECODE/EXEC/MEM/WB, with memory wait handshakes and a bounded wait timeout.
module multicycle_controller #(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [INSTR_W-1:0]    instruction_i,
    input  logic                  imem_ready_i,
    input  logic                  dmem_ready_i,
    input  logic                  alu_zero_i,
    output logic                  imem_req_o,
    output logic                  ir_write_o,
    output logic                  pc_write_o,
    output logic                  pc_src_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  mem_to_reg_o,
    output logic [1:0]            alu_op_o,
    output logic                  alu_src_o,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] read_register1_o,
    output logic [REG_ADDR_W-1:0] read_register2_o,
    output logic [REG_ADDR_W-1:0] write_register_o,
    output logic                  illegal_o,
    output logic                  mem_timeout_o
);

    localparam int unsigned OP_W  = 11;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OP_W-1:0] opcode;
    logic            is_rtype, is_ldur, is_stur, is_cbz, is_b, is_legal;
    logic            wait_hit, timeout;
    logic            unused_ir;

    assign opcode    = ir_q[INSTR_W-1 -: OP_W];
    // Only opcode and register fields are consumed; immediates belong to the datapath.
    assign unused_ir = ^ir_q;

    // Opcode decode from the held instruction
    always_comb begin
        is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                   (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
        is_ldur  = (opcode == 11'b11111000010);
        is_stur  = (opcode == 11'b11111000000);
        is_cbz   = (opcode[10:3] == 8'b10110100);
        is_b     = (opcode[10:5] == 6'b000101);
        is_legal = is_rtype || is_ldur || is_stur || is_cbz || is_b;
    end

    // This cycle is the WAIT_MAX-th consecutive one without ready
    assign wait_hit = (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_write_o) ir_q <= instruction_i;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        timeout          = 1'b0;
        imem_req_o       = 1'b0;
        ir_write_o       = 1'b0;
        pc_write_o       = 1'b0;
        pc_src_o         = 1'b0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_to_reg_o     = 1'b0;
        alu_op_o         = 2'b00;
        alu_src_o        = 1'b0;
        reg_write_o      = 1'b0;
        illegal_o        = 1'b0;
        mem_timeout_o    = 1'b0;
        read_register1_o = '0;
        read_register2_o = '0;
        write_register_o = '0;

        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    alu_op_o = 2'b10;
                    state_d  = S_WB;
                end else if (is_ldur || is_stur) begin
                    alu_src_o = 1'b1;
                    state_d   = S_MEM;
                end else if (is_cbz) begin
                    alu_op_o   = 2'b01;
                    pc_write_o = alu_zero_i;
                    pc_src_o   = alu_zero_i;
                    state_d    = S_FETCH;
                end else begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                mem_read_o  = is_ldur;
                mem_write_o = is_stur;
                if (dmem_ready_i) begin
                    state_d = is_ldur ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_ldur;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (timeout || (state_d != state_q)) cnt_d = '0;
        mem_timeout_o = timeout;

        if (state_q != S_FETCH) begin
            read_register1_o = REG_ADDR_W'(ir_q[9:5]);
            read_register2_o = (is_stur || is_cbz) ? REG_ADDR_W'(ir_q[4:0])
                                                   : REG_ADDR_W'(ir_q[20:16]);
            write_register_o = REG_ADDR_W'(ir_q[4:0]);
        end

        // Reset forces a quiet interface regardless of state
        if (reset_i) begin
            imem_req_o       = 1'b0;
            ir_write_o       = 1'b0;
            pc_write_o       = 1'b0;
            pc_src_o         = 1'b0;
            mem_read_o       = 1'b0;
            mem_write_o      = 1'b0;
            mem_to_reg_o     = 1'b0;
            alu_op_o         = 2'b00;
            alu_src_o        = 1'b0;
            reg_write_o      = 1'b0;
            illegal_o        = 1'b0;
            mem_timeout_o    = 1'b0;
            read_register1_o = '0;
            read_register2_o = '0;
            write_register_o = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors and
// register-address fields checked against hand-derived values.
module tb_multicycle_controller;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_MAX   = 15;

    // Control vector bits: imem_req ir_write pc_write pc_src mem_read mem_write
    //                      mem_to_reg alu_op[1:0] alu_src reg_write illegal mem_timeout
    localparam logic [12:0] C_IDLE     = 13'h0000;
    localparam logic [12:0] C_FETCH_RD = 13'h1C00;
    localparam logic [12:0] C_FETCH_WT = 13'h1000;
    localparam logic [12:0] C_FETCH_TO = 13'h1001;
    localparam logic [12:0] C_ILLEGAL  = 13'h0002;
    localparam logic [12:0] C_EXEC_R   = 13'h0020;
    localparam logic [12:0] C_EXEC_LS  = 13'h0008;
    localparam logic [12:0] C_EXEC_CZ1 = 13'h0610;
    localparam logic [12:0] C_EXEC_CZ0 = 13'h0010;
    localparam logic [12:0] C_EXEC_B   = 13'h0600;
    localparam logic [12:0] C_MEM_RD   = 13'h0100;
    localparam logic [12:0] C_MEM_WR   = 13'h0080;
    localparam logic [12:0] C_MEM_WTO  = 13'h0081;
    localparam logic [12:0] C_WB_R     = 13'h0004;
    localparam logic [12:0] C_WB_LD    = 13'h0044;

    localparam logic [31:0] I_ADD  = 32'h8B020023;
    localparam logic [31:0] I_LDUR = 32'hF8408085;
    localparam logic [31:0] I_STUR = 32'hF8000049;
    localparam logic [31:0] I_CBZ  = 32'hB4000047;
    localparam logic [31:0] I_B    = 32'h14000010;
    localparam logic [31:0] I_BAD  = 32'hFFE00000;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic [INSTR_W-1:0]    instruction_i;
    logic                  imem_ready_i, dmem_ready_i, alu_zero_i;
    logic                  imem_req_o, ir_write_o, pc_write_o, pc_src_o;
    logic                  mem_read_o, mem_write_o, mem_to_reg_o;
    logic [1:0]            alu_op_o;
    logic                  alu_src_o, reg_write_o, illegal_o, mem_timeout_o;
    logic [REG_ADDR_W-1:0] read_register1_o, read_register2_o, write_register_o;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(
        .INSTR_W   (INSTR_W),
        .REG_ADDR_W(REG_ADDR_W),
        .WAIT_MAX  (WAIT_MAX)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .instruction_i   (instruction_i),
        .imem_ready_i    (imem_ready_i),
        .dmem_ready_i    (dmem_ready_i),
        .alu_zero_i      (alu_zero_i),
        .imem_req_o      (imem_req_o),
        .ir_write_o      (ir_write_o),
        .pc_write_o      (pc_write_o),
        .pc_src_o        (pc_src_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .alu_op_o        (alu_op_o),
        .alu_src_o       (alu_src_o),
        .reg_write_o     (reg_write_o),
        .read_register1_o(read_register1_o),
        .read_register2_o(read_register2_o),
        .write_register_o(write_register_o),
        .illegal_o       (illegal_o),
        .mem_timeout_o   (mem_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ctl();
        return {imem_req_o, ir_write_o, pc_write_o, pc_src_o, mem_read_o, mem_write_o,
                mem_to_reg_o, alu_op_o, alu_src_o, reg_write_o, illegal_o, mem_timeout_o};
    endfunction

    // Check this cycle's control vector, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [12:0] exp);
        #1;
        check(tag, 32'(ctl()), 32'(exp));
        @(posedge clk_i);
        #2;
    endtask

    task automatic regs(input string tag, input int r1, input int r2, input int wr);
        check({tag, "_rr1"}, 32'(read_register1_o), 32'(r1));
        check({tag, "_rr2"}, 32'(read_register2_o), 32'(r2));
        check({tag, "_wr"},  32'(write_register_o), 32'(wr));
    endtask

    initial begin
        reset_i       = 1'b1;
        instruction_i = '0;
        imem_ready_i  = 1'b0;
        dmem_ready_i  = 1'b0;
        alu_zero_i    = 1'b0;
        for (int i = 0; i < 3; i++) cyc("reset", C_IDLE);

        // ADD X3,X1,X2
        reset_i = 1'b0; instruction_i = I_ADD; imem_ready_i = 1'b1;
        cyc("add_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        regs("add_dec", 1, 2, 3);
        cyc("add_dec", C_IDLE);
        cyc("add_exec", C_EXEC_R);
        check("add_wb_wr", 32'(write_register_o), 32'd3);
        cyc("add_wb", C_WB_R);

        // LDUR X5,[X4,#8] with two data wait states
        instruction_i = I_LDUR; imem_ready_i = 1'b1;
        cyc("ld_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        regs("ld_dec", 4, 0, 5);
        cyc("ld_dec", C_IDLE);
        cyc("ld_exec", C_EXEC_LS);
        cyc("ld_mem1", C_MEM_RD);
        cyc("ld_mem2", C_MEM_RD);
        dmem_ready_i = 1'b1;
        cyc("ld_mem3", C_MEM_RD);
        dmem_ready_i = 1'b0;
        cyc("ld_wb", C_WB_LD);

        // CBZ X7 taken and not taken
        instruction_i = I_CBZ; imem_ready_i = 1'b1; alu_zero_i = 1'b1;
        cyc("cbz1_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        check("cbz1_rr2", 32'(read_register2_o), 32'd7);
        cyc("cbz1_dec", C_IDLE);
        cyc("cbz1_exec", C_EXEC_CZ1);
        imem_ready_i = 1'b1; alu_zero_i = 1'b0;
        cyc("cbz0_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        cyc("cbz0_dec", C_IDLE);
        cyc("cbz0_exec", C_EXEC_CZ0);

        // Unconditional branch
        instruction_i = I_B; imem_ready_i = 1'b1;
        cyc("b_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        cyc("b_dec", C_IDLE);
        cyc("b_exec", C_EXEC_B);

        // STUR X9,[X2] with dmem never ready: timeout on the 15th MEM cycle
        instruction_i = I_STUR; imem_ready_i = 1'b1;
        cyc("st_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        regs("st_dec", 2, 9, 9);
        cyc("st_dec", C_IDLE);
        cyc("st_exec", C_EXEC_LS);
        for (int i = 0; i < 14; i++) cyc("st_mem_wait", C_MEM_WR);
        cyc("st_timeout", C_MEM_WTO);

        // Instruction fetch starved: timeout on the 15th FETCH cycle, stays in FETCH
        for (int i = 0; i < 14; i++) cyc("if_wait", C_FETCH_WT);
        cyc("if_timeout", C_FETCH_TO);
        cyc("if_after_to", C_FETCH_WT);

        // STUR with ready on the boundary cycle: success, no timeout
        instruction_i = I_STUR; imem_ready_i = 1'b1;
        cyc("st2_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        cyc("st2_dec", C_IDLE);
        cyc("st2_exec", C_EXEC_LS);
        for (int i = 0; i < 14; i++) cyc("st2_mem_wait", C_MEM_WR);
        dmem_ready_i = 1'b1;
        cyc("st2_mem_edge", C_MEM_WR);
        dmem_ready_i = 1'b0;
        cyc("st2_back_fetch", C_FETCH_WT);

        // Illegal opcode 0x7FF
        instruction_i = I_BAD; imem_ready_i = 1'b1;
        cyc("bad_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        cyc("bad_dec", C_ILLEGAL);
        cyc("bad_back_fetch", C_FETCH_WT);

        // Reset during LDUR MEM phase
        instruction_i = I_LDUR; imem_ready_i = 1'b1;
        cyc("rl_fetch", C_FETCH_RD);
        imem_ready_i = 1'b0;
        cyc("rl_dec", C_IDLE);
        cyc("rl_exec", C_EXEC_LS);
        cyc("rl_mem", C_MEM_RD);
        reset_i = 1'b1;
        cyc("rl_reset1", C_IDLE);
        cyc("rl_reset2", C_IDLE);
        reset_i = 1'b0;
        cyc("rl_fetch_after", C_FETCH_WT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
